// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared op/state types and conditional negation for the HI/LO unit
package mips_muldiv_pkg;
  localparam int NEG_W = 128;
  typedef logic [NEG_W-1:0] wide_t;
  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} muldiv_state_t;
  function automatic wide_t neg_if(input wide_t value, input logic cond);
    return cond ? -value : value;
  endfunction
endpackage

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int W2 = 2 * WIDTH;
  muldiv_state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, b_mag, mag_a, mag_b;
  logic             is_div, dz, sign_q, sign_r;
  logic             is_muldiv, op_div, op_signed, div_ok;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  assign busy      = state != IDLE;
  assign is_muldiv = op inside {MULT, MULTU, DIV, DIVU};
  assign op_div    = op == DIV || op == DIVU;
  assign op_signed = op == MULT || op == DIV;
  assign mag_a     = WIDTH'(neg_if(wide_t'(rs_data), op_signed && rs_data[WIDTH-1]));
  assign mag_b     = WIDTH'(neg_if(wide_t'(rt_data), op_signed && rt_data[WIDTH-1]));
  // Multiply: right-shifting add of b into the upper half, multiplier consumed from acc_lo[0]
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, acc_lo[0] ? b_mag : '0};
  // Divide: restoring step, quotient bits shift into acc_lo as dividend bits shift out
  assign div_sh    = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_sh - {1'b0, b_mag};
  assign div_ok    = !div_diff[WIDTH];
  assign prod_fix  = W2'(neg_if(wide_t'({acc_hi, acc_lo}), sign_q));
  assign quot_fix  = WIDTH'(neg_if(wide_t'(acc_lo), sign_q));
  assign rem_fix   = WIDTH'(neg_if(wide_t'(acc_hi), sign_r));
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = (start && is_muldiv) ? ((op_div && rt_data == '0) ? FIXUP : RUN) : IDLE;
      RUN:     next_state = (cnt == CNT_W'(1)) ? FIXUP : RUN;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      b_mag       <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          div_by_zero <= 1'b0;
          if (op == MTHI) hi <= rs_data;
          if (op == MTLO) lo <= rs_data;
          is_div <= op_div;
          dz     <= op_div && rt_data == '0;
          sign_q <= op_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          sign_r <= op_signed && rs_data[WIDTH-1];
          acc_hi <= '0;
          acc_lo <= (op_div && rt_data == '0) ? rs_data : mag_a;
          b_mag  <= mag_b;
          cnt    <= CNT_W'(WIDTH);
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else
            {acc_hi, acc_lo} <= W2'({mul_sum, acc_lo} >> 1);
        end
        default: begin
          done <= 1'b1;
          if (dz) begin
            hi          <= acc_lo;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else
            {hi, lo} <= prod_fix;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed scoreboard bench for the iterative HI/LO unit
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  muldiv_op_t  op = MULTU;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int lat, input bit poke);
    int n;
    int nb;
    exp_t got;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    n = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 200) begin
      start = poke && n == 5;
      if (start) begin op = MTLO; rs_data = 32'hABCD_0123; end
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nb++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    if (done && sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, "_hi"}, hi, got.hi);
      chk({tag, "_lo"}, lo, got.lo);
      chk({tag, "_dz"}, 32'(div_by_zero), 32'(got.dz));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      chk({tag, "_busy_cycles"}, 32'(nb), 32'(lat));
    end else sb.delete();
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask
  task automatic move(input string tag, input muldiv_op_t o, input logic [31:0] a,
                      input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_dz"}, 32'(div_by_zero), 32'd0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}, 33, 1'b0);
    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}, 33, 1'b0);
    run_op("mult_minmin", MULT, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0, 1'b0}, 33, 1'b0);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 33, 1'b0);
    run_op("divu", DIVU, 32'd7, 32'd2, '{32'd1, 32'd3, 1'b0}, 33, 1'b0);
    run_op("divu_zero", DIVU, 32'h1234_5678, 32'd0, '{32'h1234_5678, 32'hFFFF_FFFF, 1'b1}, 1, 1'b0);
    move("mtlo_clr", MTLO, 32'h0000_0055, 32'h1234_5678, 32'h0000_0055);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0, 32'h8000_0000, 1'b0}, 33, 1'b0);
    move("mthi", MTHI, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000);
    run_op("multu_poke", MULTU, 32'd2, 32'd3, '{32'd0, 32'd6, 1'b0}, 33, 1'b1);
    move("mthi_alone", MTHI, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd6);
    sb.push_back('{32'd2, 32'd14, 1'b0});
    @(negedge clk);
    start = 1'b1; op = DIVU; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    run_op("divu_after_abort", DIVU, 32'd100, 32'd7, '{32'd2, 32'd14, 1'b0}, 33, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
